instr_encoder: RTL
==================

Name: instr_encoder

Overview:
- Encodes LEGv8 instruction fields into 32-bit instruction words. It is the inverse of the decode-side sign extension.
- Narrows signed immediates and absolute branch targets back into the DAddr9, Imm12, CondAddr19 and BrAddr26 fields, and range-checks each one.
- Tracks the PC of the next emitted word and buffers encoded words in a small FIFO.
- Feeds instruction-memory preload logic and self-test stream generators.

Parameters:
- DEPTH, 4, output FIFO entries (power of 2, ≥2).
- PC_BASE, 64'h0, PC value after reset.

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- pc_load  in  1  load PC origin this cycle
- pc_value  in  64  new PC origin (must be 4-byte aligned)
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- fmt  in  3  0=R, 1=I, 2=D, 3=B, 4=CB, 5..7 illegal
- opcode  in  11  opcode, left-aligned use: R/D [10:0], I [10:1], CB [10:3], B [10:5]
- rd  in  5  Rd/Rt
- rn  in  5  Rn
- rm  in  5  Rm
- shamt  in  6  R-type shift amount
- imm  in  64  signed immediate (I) or byte offset (D)
- target  in  64  absolute byte address (B/CB)
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer takes head
- out_instr  out  32  encoded word
- out_pc  out  64  address of out_instr
- err  out  1  one-cycle pulse: request rejected
- err_code  out  3  001 imm range, 010 target misaligned, 011 branch range, 100 illegal fmt; 000 when err=0

Behaviour:
- Reset (async, reset_n=0), outputs immediately:
  - FIFO empty; out_valid=0, out_instr=0, out_pc=0.
  - err=0, err_code=0.
  - pc=PC_BASE; in_ready=1 once reset is released.
- in_ready = (count<DEPTH) & ~pc_load. This does not depend on out_ready, so a full FIFO blocks input even while popping.
- pc_load:
  - pc<=pc_value at the edge.
  - Any in_valid that cycle is not accepted.
- Accept cycle: the encoding is computed combinationally from the inputs and the current pc.
- Valid request:
  - The word and pc are pushed to the FIFO at the edge, and pc<=pc+4.
  - Visible at out_* on the next cycle at the earliest (latency 1).
- Rejected request:
  - No push, pc unchanged.
  - err=1 with err_code for exactly the cycle after the accepting edge.
  - err is registered; a rejected request still consumes the handshake.
- Encodings:
  - R: {opcode[10:0], rm, shamt, rn, rd}.
  - I: {opcode[10:1], imm[11:0], rn, rd}; error 001 unless imm ∈ [-2048, 2047] (imm[63:11] all equal).
  - D: {opcode[10:0], imm[8:0], 2'b00, rn, rd}; error 001 unless imm ∈ [-256, 255].
  - B: off=(target-pc)>>>2 (arithmetic); {opcode[10:5], off[25:0]}; error 011 unless off fits signed 26 bits.
  - CB: off as for B; {opcode[10:3], off[18:0], rd}; error 011 unless off fits signed 19 bits.
- Error priority: 100 > 010 (target[1:0]≠0, B/CB only) > 011/001.
- Subtraction is 64-bit wrap-around; the range check is applied to the 64-bit difference.
- FIFO:
  - Circular, with pointers that wrap modulo DEPTH.
  - Pop when out_valid & out_ready.
  - Simultaneous push and pop with 0<count<DEPTH: count unchanged, order preserved.
  - Push into an empty FIFO: head appears next cycle, with no bypass.
- out_instr and out_pc are driven from the head entry.
- When empty, out_instr and out_pc hold their last value.
- pc wraps from 2^64-4 to 0 without error.

Test Plan:
- Reset, then release -> out_valid=0, in_ready=1, err=0; with PC_BASE=0, the first accepted word has out_pc=0.
- I-type: opcode[10:1]=10'b1001000100, imm=-1, rn=2, rd=3 -> out_instr=32'h913FFC43, out_pc=0. The same request with imm=2048 -> err=1, err_code=001, no push, next word still at pc=4.
- pc_load 0x1000, then:
  - B, opcode[10:5]=6'b000101, target=0xFF8 -> out_instr=32'h17FFFFFE, out_pc=0x1000.
  - CB, opcode[10:3]=8'b10110100, rd=1, target=0x100C -> off=2, out_instr=32'hB4000041, out_pc=0x1004.
- B with target=0x1002 -> err_code=010. B with target=pc+2^27 -> err_code=011. fmt=6 -> err_code=100. In all three cases pc is unchanged.
- out_ready=0, push 4 R-type words -> in_ready=0 after the 4th, and a held 5th request is not accepted. Then out_ready=1 -> words pop in order with out_pc 0x1000/1004/1008/100C, and the 5th is accepted once a slot frees.
- With 3 entries queued, pulse reset_n low mid-cycle -> out_valid falls immediately; after release the FIFO is empty and the next word has out_pc=PC_BASE.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Request/response bundle for instr_encoder: field-level request in, encoded words and error pulse out.
interface instr_encoder_if;
    logic        pc_load;
    logic [63:0] pc_value;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fmt;
    logic [10:0] opcode;
    logic [4:0]  rd;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [5:0]  shamt;
    logic [63:0] imm;
    logic [63:0] target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        err;
    logic [2:0]  err_code;

    modport master (
        output pc_load, pc_value, in_valid, fmt, opcode, rd, rn, rm, shamt, imm, target, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, err, err_code
    );

    modport slave (
        input  pc_load, pc_value, in_valid, fmt, opcode, rd, rn, rm, shamt, imm, target, out_ready,
        output in_ready, out_valid, out_instr, out_pc, err, err_code
    );
endinterface

// File: rtl/instr_encoder.sv
// LEGv8 field-to-word encoder with immediate/branch range checks, PC tracking
// and a small output FIFO of {word, pc} pairs.
module instr_encoder #(
    parameter int unsigned DEPTH   = 4,
    parameter logic [63:0] PC_BASE = 64'h0
) (
    input logic           clk,
    input logic           reset_n,
    instr_encoder_if.slave bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    localparam logic [2:0] FMT_R  = 3'd0;
    localparam logic [2:0] FMT_I  = 3'd1;
    localparam logic [2:0] FMT_D  = 3'd2;
    localparam logic [2:0] FMT_B  = 3'd3;
    localparam logic [2:0] FMT_CB = 3'd4;

    localparam logic [2:0] ERR_NONE  = 3'b000;
    localparam logic [2:0] ERR_IMM   = 3'b001;
    localparam logic [2:0] ERR_ALIGN = 3'b010;
    localparam logic [2:0] ERR_RANGE = 3'b011;
    localparam logic [2:0] ERR_FMT   = 3'b100;

    logic [63:0]   pc_q;
    logic [31:0]   mem_instr [DEPTH];
    logic [63:0]   mem_pc    [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [31:0]   last_instr;
    logic [63:0]   last_pc;
    logic          err_q;
    logic [2:0]    err_code_q;

    logic [63:0] diff_c;
    logic [63:0] off_c;
    logic [31:0] word_c;
    logic [2:0]  code_c;
    logic        in_ready_c;
    logic        accept_c;
    logic        push_c;
    logic        pop_c;
    logic        not_empty_c;

    // Branch offset in words relative to the PC this word will occupy.
    assign diff_c = bus.target - pc_q;
    assign off_c  = 64'($signed(diff_c) >>> 2);

    // Field packing and range checks; fmt error outranks alignment, which outranks range.
    always_comb begin
        word_c = 32'h0;
        code_c = ERR_NONE;
        case (bus.fmt)
            FMT_R: word_c = {bus.opcode, bus.rm, bus.shamt, bus.rn, bus.rd};
            FMT_I: begin
                word_c = {bus.opcode[10:1], bus.imm[11:0], bus.rn, bus.rd};
                if (!((&bus.imm[63:11]) || !(|bus.imm[63:11])))
                    code_c = ERR_IMM;
            end
            FMT_D: begin
                word_c = {bus.opcode, bus.imm[8:0], 2'b00, bus.rn, bus.rd};
                if (!((&bus.imm[63:8]) || !(|bus.imm[63:8])))
                    code_c = ERR_IMM;
            end
            FMT_B: begin
                word_c = {bus.opcode[10:5], off_c[25:0]};
                if (bus.target[1:0] != 2'b00)
                    code_c = ERR_ALIGN;
                else if (!((&off_c[63:25]) || !(|off_c[63:25])))
                    code_c = ERR_RANGE;
            end
            FMT_CB: begin
                word_c = {bus.opcode[10:3], off_c[18:0], bus.rd};
                if (bus.target[1:0] != 2'b00)
                    code_c = ERR_ALIGN;
                else if (!((&off_c[63:18]) || !(|off_c[63:18])))
                    code_c = ERR_RANGE;
            end
            default: code_c = ERR_FMT;
        endcase
    end

    assign not_empty_c = (count != CW'(0));
    assign in_ready_c  = (count < CW'(DEPTH)) && !bus.pc_load;
    assign accept_c    = bus.in_valid && in_ready_c;
    assign push_c      = accept_c && (code_c == ERR_NONE);
    assign pop_c       = not_empty_c && bus.out_ready;

    // Storage has no reset; visibility is governed entirely by count.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_instr[wr_ptr] <= word_c;
            mem_pc[wr_ptr]    <= pc_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q       <= PC_BASE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            last_instr <= 32'h0;
            last_pc    <= 64'h0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            if (bus.pc_load)
                pc_q <= bus.pc_value;
            else if (push_c)
                pc_q <= pc_q + 64'd4;

            if (push_c)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop_c)
                rd_ptr <= rd_ptr + AW'(1);

            case ({push_c, pop_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            // Remember the head so outputs hold once the FIFO drains.
            if (not_empty_c) begin
                last_instr <= mem_instr[rd_ptr];
                last_pc    <= mem_pc[rd_ptr];
            end

            err_q      <= accept_c && (code_c != ERR_NONE);
            err_code_q <= accept_c ? code_c : ERR_NONE;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = not_empty_c;
    assign bus.out_instr = not_empty_c ? mem_instr[rd_ptr] : last_instr;
    assign bus.out_pc    = not_empty_c ? mem_pc[rd_ptr]    : last_pc;
    assign bus.err       = err_q;
    assign bus.err_code  = err_code_q;
endmodule
